// File: rtl/onehot_select_seq_if.sv
// Command/select bus for onehot_select_seq: command handshake in, one-hot select and status out.
interface onehot_select_seq_if #(
   parameter int unsigned SEL_W = 3
);
   localparam int unsigned OUT_W = 2 ** SEL_W;

   logic             enable;
   logic             in_valid;
   logic             in_ready;
   logic [SEL_W-1:0] sel;
   logic [1:0]       mode;
   logic [OUT_W-1:0] out;
   logic             busy;
   logic             done;

   // Command source / status consumer
   modport master (
      output enable, in_valid, sel, mode,
      input  in_ready, out, busy, done
   );

   // Select sequencer
   modport slave (
      input  enable, in_valid, sel, mode,
      output in_ready, out, busy, done
   );
endinterface

// File: rtl/onehot_select_seq.sv
// Registered one-hot select sequencer: level-hold, timed pulse and upward auto-scan modes.
module onehot_select_seq #(
   parameter int unsigned SEL_W     = 3,
   parameter int unsigned PULSE_LEN = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   onehot_select_seq_if.slave   bus
);
   localparam int unsigned OUT_W = 2 ** SEL_W;
   localparam int unsigned CNT_W = 8;

   localparam logic [1:0] LP_MODE_PULSE = 2'b01;
   localparam logic [1:0] LP_MODE_SCAN  = 2'b10;

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(PULSE_LEN - 1);
   localparam logic [SEL_W-1:0] LP_IDX_LAST = SEL_W'(OUT_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_PULSE = 2'd2,
      ST_SCAN  = 2'd3
   } state_t;

   state_t             r_state;
   logic [OUT_W-1:0]   r_out;
   logic               r_busy;
   logic               r_done;
   logic [CNT_W-1:0]   r_cnt;
   logic [SEL_W-1:0]   r_idx;

   state_t             w_state_nxt;
   logic [OUT_W-1:0]   w_out_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [SEL_W-1:0]   w_idx_nxt;

   logic               w_in_ready;
   logic               w_accept;
   logic [OUT_W-1:0]   w_sel_onehot;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic [SEL_W-1:0]   w_idx_inc;

   // Handshake: commands are only taken while enabled and not sequencing
   always_comb begin
      w_in_ready   = bus.enable && ((r_state == ST_IDLE) || (r_state == ST_HOLD));
      w_accept     = w_in_ready && bus.in_valid;
      w_sel_onehot = OUT_W'(1) << bus.sel;
      w_cnt_inc    = r_cnt + CNT_W'(1);
      w_idx_inc    = r_idx + SEL_W'(1);
   end

   assign bus.in_ready = w_in_ready;
   assign bus.out      = r_out;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_out   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_out   <= w_out_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Next-state and next-output logic; done is raised when entering the final active cycle
   always_comb begin
      w_state_nxt = r_state;
      w_out_nxt   = r_out;
      w_done_nxt  = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;

      if (!bus.enable) begin
         w_state_nxt = ST_IDLE;
         w_out_nxt   = '0;
         w_cnt_nxt   = '0;
         w_idx_nxt   = '0;
      end else begin
         unique case (r_state)
            ST_IDLE, ST_HOLD: begin
               if (r_state == ST_IDLE) begin
                  w_out_nxt = '0;
               end
               if (w_accept) begin
                  // New select replaces the old one directly, no zero gap from HOLD
                  w_out_nxt = w_sel_onehot;
                  if (bus.mode == LP_MODE_PULSE) begin
                     w_state_nxt = ST_PULSE;
                     w_cnt_nxt   = '0;
                     w_done_nxt  = (LP_CNT_LAST == '0);
                  end else if (bus.mode == LP_MODE_SCAN) begin
                     w_state_nxt = ST_SCAN;
                     w_idx_nxt   = bus.sel;
                     w_done_nxt  = (bus.sel == LP_IDX_LAST);
                  end else begin
                     w_state_nxt = ST_HOLD;
                  end
               end
            end
            ST_PULSE: begin
               if (r_cnt == LP_CNT_LAST) begin
                  w_state_nxt = ST_IDLE;
                  w_out_nxt   = '0;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt  = w_cnt_inc;
                  w_done_nxt = (w_cnt_inc == LP_CNT_LAST);
               end
            end
            ST_SCAN: begin
               // Explicit end compare; the index never wraps
               if (r_idx == LP_IDX_LAST) begin
                  w_state_nxt = ST_IDLE;
                  w_out_nxt   = '0;
                  w_idx_nxt   = '0;
               end else begin
                  w_idx_nxt  = w_idx_inc;
                  w_out_nxt  = OUT_W'(1) << w_idx_inc;
                  w_done_nxt = (w_idx_inc == LP_IDX_LAST);
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_out_nxt   = '0;
            end
         endcase
      end

      w_busy_nxt = (w_state_nxt == ST_PULSE) || (w_state_nxt == ST_SCAN);
   end
endmodule

// File: tb/tb_onehot_select_seq.sv
// Directed bench for onehot_select_seq: one 3-bit/PULSE_LEN=3 instance and one 4-bit/PULSE_LEN=1 instance.
module tb_onehot_select_seq;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   onehot_select_seq_if #(.SEL_W(3)) if_a ();
   onehot_select_seq_if #(.SEL_W(4)) if_b ();

   onehot_select_seq #(.SEL_W(3), .PULSE_LEN(3)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a.slave)
   );

   onehot_select_seq #(.SEL_W(4), .PULSE_LEN(1)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and land just after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd_a(input logic [1:0] m, input logic [2:0] s);
      if_a.in_valid = 1'b1;
      if_a.mode     = m;
      if_a.sel      = s;
   endtask

   // Invariants on every cycle: one-hot-or-zero select, done only while busy
   always @(negedge clk) begin
      check("onehot_a",    32'($onehot0(if_a.out)), 32'd1);
      check("onehot_b",    32'($onehot0(if_b.out)), 32'd1);
      check("done_busy_a", 32'(!if_a.done || if_a.busy), 32'd1);
      check("done_busy_b", 32'(!if_b.done || if_b.busy), 32'd1);
   end

   initial begin
      logic [31:0] scan_exp [3];
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      if_a.enable = 1'b0; if_a.in_valid = 1'b0; if_a.mode = 2'b00; if_a.sel = '0;
      if_b.enable = 1'b0; if_b.in_valid = 1'b0; if_b.mode = 2'b00; if_b.sel = '0;
      cyc();
      cyc();
      check("rst_out",   32'(if_a.out),      32'h0);
      check("rst_busy",  32'(if_a.busy),     32'h0);
      check("rst_done",  32'(if_a.done),     32'h0);
      check("rst_ready_dis", 32'(if_a.in_ready), 32'h0);
      if_a.enable = 1'b1;
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(if_a.in_ready), 32'h1);
      cyc();

      // LEVEL sel=5 held, then replaced by sel=2 with no zero gap
      cmd_a(2'b00, 3'd5);
      check("lvl_ready", 32'(if_a.in_ready), 32'h1);
      cyc();
      if_a.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("lvl_hold_20", 32'(if_a.out), 32'h20);
         check("lvl_busy",    32'(if_a.busy), 32'h0);
         if (i < 2) cyc();
      end
      cmd_a(2'b00, 3'd2);
      cyc();
      if_a.in_valid = 1'b0;
      check("lvl_replace_04", 32'(if_a.out), 32'h04);
      cyc();
      check("lvl_hold_04", 32'(if_a.out), 32'h04);
      if_a.enable = 1'b0;
      cyc();
      check("lvl_disable", 32'(if_a.out), 32'h0);
      if_a.enable = 1'b1;
      cyc();

      // PULSE sel=1, PULSE_LEN=3
      cmd_a(2'b01, 3'd1);
      cyc();
      if_a.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("pls_out",   32'(if_a.out),      32'h02);
         check("pls_busy",  32'(if_a.busy),     32'h1);
         check("pls_done",  32'(if_a.done),     (i == 2) ? 32'h1 : 32'h0);
         check("pls_ready", 32'(if_a.in_ready), 32'h0);
         cyc();
      end
      check("pls_end_out",   32'(if_a.out),      32'h0);
      check("pls_end_busy",  32'(if_a.busy),     32'h0);
      check("pls_end_done",  32'(if_a.done),     32'h0);
      check("pls_end_ready", 32'(if_a.in_ready), 32'h1);

      // SCAN sel=5 -> 20,40,80
      scan_exp[0] = 32'h20; scan_exp[1] = 32'h40; scan_exp[2] = 32'h80;
      cmd_a(2'b10, 3'd5);
      cyc();
      if_a.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("scan5_out",  32'(if_a.out),  scan_exp[i]);
         check("scan5_done", 32'(if_a.done), (i == 2) ? 32'h1 : 32'h0);
         check("scan5_busy", 32'(if_a.busy), 32'h1);
         cyc();
      end
      check("scan5_end_out",  32'(if_a.out),  32'h0);
      check("scan5_end_busy", 32'(if_a.busy), 32'h0);

      // SCAN sel=7 -> single cycle with done
      cmd_a(2'b10, 3'd7);
      cyc();
      if_a.in_valid = 1'b0;
      check("scan7_out",  32'(if_a.out),  32'h80);
      check("scan7_done", 32'(if_a.done), 32'h1);
      cyc();
      check("scan7_end_out",  32'(if_a.out),  32'h0);
      check("scan7_end_busy", 32'(if_a.busy), 32'h0);

      // SCAN sel=0 with a pending LEVEL sel=6 held during busy, then abort via enable
      cmd_a(2'b10, 3'd0);
      cyc();
      if_a.mode = 2'b00;
      if_a.sel  = 3'd6;
      for (int i = 0; i < 4; i++) begin
         check("abort_out",   32'(if_a.out),      32'(1 << i));
         check("abort_done",  32'(if_a.done),     32'h0);
         check("abort_ready", 32'(if_a.in_ready), 32'h0);
         if (i < 3) cyc();
      end
      if_a.enable = 1'b0;
      #1;
      check("abort_ready_dis", 32'(if_a.in_ready), 32'h0);
      cyc();
      check("abort_end_out",  32'(if_a.out),  32'h0);
      check("abort_end_busy", 32'(if_a.busy), 32'h0);
      check("abort_end_done", 32'(if_a.done), 32'h0);
      if_a.in_valid = 1'b0;
      if_a.enable   = 1'b1;
      cyc();
      check("abort_idle_ready", 32'(if_a.in_ready), 32'h1);

      // Async reset between edges in the middle of a scan
      cmd_a(2'b10, 3'd0);
      cyc();
      if_a.in_valid = 1'b0;
      cyc();
      check("pre_rst_out", 32'(if_a.out), 32'h02);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_out",  32'(if_a.out),  32'h0);
      check("async_rst_busy", 32'(if_a.busy), 32'h0);
      check("async_rst_done", 32'(if_a.done), 32'h0);
      cyc();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(if_a.in_ready), 32'h1);
      cyc();

      // SEL_W=4: reserved mode executes as LEVEL
      if_a.enable = 1'b0;
      if_b.enable = 1'b1;
      if_b.in_valid = 1'b1; if_b.mode = 2'b11; if_b.sel = 4'd15;
      cyc();
      if_b.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("b_rsvd_out",  32'(if_b.out),  32'h8000);
         check("b_rsvd_busy", 32'(if_b.busy), 32'h0);
         cyc();
      end
      if_b.enable = 1'b0;
      cyc();
      check("b_disable_out", 32'(if_b.out), 32'h0);
      if_b.enable = 1'b1;

      // PULSE_LEN=1: single cycle with coincident done
      if_b.in_valid = 1'b1; if_b.mode = 2'b01; if_b.sel = 4'd9;
      cyc();
      if_b.in_valid = 1'b0;
      check("b_pls1_out",  32'(if_b.out),  32'h0200);
      check("b_pls1_done", 32'(if_b.done), 32'h1);
      cyc();
      check("b_pls1_end_out",  32'(if_b.out),  32'h0);
      check("b_pls1_end_busy", 32'(if_b.busy), 32'h0);

      // Random-command soak; the per-cycle monitor carries the checks
      if_a.enable = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if_a.enable   = ($urandom_range(0, 15) != 0);
         if_a.in_valid = 1'($urandom_range(0, 1));
         if_a.mode     = 2'($urandom_range(0, 3));
         if_a.sel      = 3'($urandom_range(0, 7));
         if_b.enable   = ($urandom_range(0, 15) != 0);
         if_b.in_valid = 1'($urandom_range(0, 1));
         if_b.mode     = 2'($urandom_range(0, 3));
         if_b.sel      = 4'($urandom_range(0, 15));
         cyc();
      end
      if_a.enable = 1'b0;
      if_b.enable = 1'b0;
      cyc();
      check("soak_end_a", 32'(if_a.out), 32'h0);
      check("soak_end_b", 32'(if_b.out), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
